code_lock_ctrl: RTL

//  Password-lock controller sitting directly downstream of the 3x4 keypad scanner.

---
 rtl/code_lock_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/code_lock_ctrl.sv
// Password lock controller fed by the keypad scanner's key_flag/key_value stream.
// Latency: unlock rises 2 cycles after the '#' key event (CHECK, then OPEN); all outputs registered.
// Backpressure: none; key events arriving in CHECK/FAIL (and LOCKOUT) are dropped.
//
// Optional feature: define LOCKOUT_EN to add a LOCKOUT state entered after
// MAX_FAIL consecutive wrong codes. Without it, locked_out is tied 0.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_flag   1-cycle press pulse from the scanner; key_value valid the cycle after
//   key_value  0-9 digit, 10 '*' (clear/set), 11 '#' (enter), 12-15 ignored
//   unlock     high while the lock is open
//   set_mode   high while a new password is being entered
//   err_pulse  1-cycle pulse on a wrong password or an aborted password change
//   digit_cnt  number of digits currently buffered
//   locked_out high while locked out (LOCKOUT_EN only)
module code_lock_ctrl #(
    parameter int unsigned                  PW_LEN      = 4,
    parameter logic [4*PW_LEN-1:0]          DEFAULT_PW  = 16'h1234,
    parameter int unsigned                  OPEN_CYCLES = 250_000_000,
    parameter int unsigned                  MAX_FAIL    = 3,
    parameter int unsigned                  LOCK_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic [3:0] key_value,
    output logic       unlock,
    output logic       set_mode,
    output logic       err_pulse,
    output logic [2:0] digit_cnt,
    output logic       locked_out
);

    localparam int unsigned BW      = 4 * PW_LEN;
    localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] OPEN_TC = TW'(OPEN_CYCLES - 1);
    localparam logic [2:0]    LEN3    = 3'(PW_LEN);
`ifdef LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_TC  = TW'(LOCK_CYCLES - 1);
    // fail_cnt saturates at 7, so a larger threshold could never be reached
    localparam logic [2:0]    FAIL_LIM = (MAX_FAIL > 7) ? 3'd7 : 3'(MAX_FAIL);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FAIL,
        S_OPEN,
        S_SET
`ifdef LOCKOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] entry_buf, buf_nxt;
    logic [BW-1:0] pw, pw_nxt;
    logic [2:0]    cnt_nxt;
    logic [2:0]    fail_cnt, fail_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          flag_d;
    logic          unlock_nxt, set_mode_nxt, err_nxt, locked_nxt;

    // Scanner presents key_value one cycle after key_flag, so the delayed
    // flag marks the cycle in which key_value is meaningful.
    logic key_digit, key_star, key_hash;
    assign key_digit = flag_d && (key_value <= 4'd9);
    assign key_star  = flag_d && (key_value == 4'd10);
    assign key_hash  = flag_d && (key_value == 4'd11);

    // Entry buffer with the new digit shifted in at the least significant
    // nibble (first digit ends up most significant).
    logic [BW-1:0] buf_shift;
    if (PW_LEN == 1) begin : g_one_digit
        assign buf_shift = key_value;
    end else begin : g_multi_digit
        assign buf_shift = {entry_buf[BW-5:0], key_value};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            entry_buf  <= '0;
            pw         <= DEFAULT_PW;
            digit_cnt  <= 3'd0;
            fail_cnt   <= 3'd0;
            timer      <= '0;
            flag_d     <= 1'b0;
            unlock     <= 1'b0;
            set_mode   <= 1'b0;
            err_pulse  <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            entry_buf  <= buf_nxt;
            pw         <= pw_nxt;
            digit_cnt  <= cnt_nxt;
            fail_cnt   <= fail_nxt;
            timer      <= timer_nxt;
            flag_d     <= key_flag;
            unlock     <= unlock_nxt;
            set_mode   <= set_mode_nxt;
            err_pulse  <= err_nxt;
            locked_out <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        buf_nxt      = entry_buf;
        cnt_nxt      = digit_cnt;
        pw_nxt       = pw;
        fail_nxt     = fail_cnt;
        timer_nxt    = timer;
        err_nxt      = 1'b0;

        case (state)
            S_IDLE, S_SET: begin
                if (key_digit) begin
                    // digits beyond the password length are silently dropped
                    if (digit_cnt < LEN3) begin
                        buf_nxt = buf_shift;
                        cnt_nxt = digit_cnt + 3'd1;
                    end
                end else if (key_star) begin
                    buf_nxt = '0;
                    cnt_nxt = 3'd0;
                end else if (key_hash) begin
                    if (state == S_IDLE) begin
                        state_nxt = S_CHECK;
                    end else begin
                        // Leaving SET always empties the buffer so a stale
                        // entry can never be replayed against the new password.
                        if (digit_cnt == LEN3) begin
                            pw_nxt = entry_buf;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        buf_nxt   = '0;
                        cnt_nxt   = 3'd0;
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_CHECK: begin
                if ((digit_cnt == LEN3) && (entry_buf == pw)) begin
                    state_nxt = S_OPEN;
                    fail_nxt  = 3'd0;
                    timer_nxt = '0;
                end else begin
                    state_nxt = S_FAIL;
                    fail_nxt  = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
                end
                buf_nxt = '0;
                cnt_nxt = 3'd0;
            end

            S_FAIL: begin
`ifdef LOCKOUT_EN
                if (fail_cnt >= FAIL_LIM) begin
                    state_nxt = S_LOCKOUT;
                    timer_nxt = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end

            S_OPEN: begin
                // A '#' or '*' in the terminal-count cycle takes priority
                // over the timeout.
                if (key_hash) begin
                    state_nxt = S_IDLE;
                end else if (key_star) begin
                    state_nxt = S_SET;
                    buf_nxt   = '0;
                    cnt_nxt   = 3'd0;
                end else if (timer == OPEN_TC) begin
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

`ifdef LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer == LOCK_TC) begin
                    state_nxt = S_IDLE;
                    fail_nxt  = 3'd0;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
`endif

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registers line up
        // with the state they describe.
        unlock_nxt   = (state_nxt == S_OPEN);
        set_mode_nxt = (state_nxt == S_SET);
        err_nxt      = err_nxt || (state_nxt == S_FAIL);
`ifdef LOCKOUT_EN
        locked_nxt   = (state_nxt == S_LOCKOUT);
`else
        locked_nxt   = 1'b0;
`endif
    end

endmodule
